mem_wb_stage: RTL
=================

# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register. It consumes the MEM_* bundle produced by the EX/MEM register and drives a req/ack data-memory port with byte-lane alignment and load extension. It stalls the front of the pipe while an access is outstanding and presents a registered WB_* bundle to the register file. It carries the same interrupt snapshot/restore behaviour as the upstream pipeline registers.

## Interface
- DM_CTRL_W, 3: width of dm_ctrl.
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- INT_detected  in  1  interrupt taken; snapshot WB bundle, drive bubble.
- INT_restore  in  1  reload WB bundle from snapshot.
- MEM_PC  in  32  instruction PC.
- MEM_rd  in  5  destination register.
- MEM_RD2  in  32  store data.
- MEM_dm_ctrl  in  3  access size/sign: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned.
- MEM_RegWrite  in  1  register write enable.
- MEM_mem_w  in  1  store.
- MEM_aluout  in  32  ALU result / effective address.
- MEM_WDSel  in  2  00 aluout, 01 load data, 10 PC+4.
- dm_req  out  1  memory request.
- dm_we  out  1  write strobe.
- dm_addr  out  32  word-aligned address (aluout & ~3).
- dm_be  out  4  byte enables.
- dm_wdata  out  32  store data replicated into lanes.
- dm_rdata  in  32  read data, valid with dm_ack.
- dm_ack  in  1  access complete.
- MEM_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- MEM_misalign  out  1  one-cycle pulse on a misaligned access.
- WB_PC  out  32
- WB_rd  out  5
- WB_RegWrite  out  1
- WB_WD  out  32  write-back data.

## Operation
- Memory op = MEM_mem_w, or MEM_WDSel==01 (load).
- Misaligned: word with addr[1:0]!=0; half with addr[0]!=0. No request is issued, MEM_misalign pulses, and the instruction is retired with RegWrite=0.
- FSM states:
  - IDLE:
    - A memory op asserts dm_req combinationally.
    - With dm_ack in the same cycle, the access completes with zero wait and state stays IDLE.
    - Otherwise MEM_stall=1 and the next state is WAIT.
  - WAIT:
    - dm_req, dm_we, dm_addr, dm_be and dm_wdata are held from registered copies.
    - MEM_stall=1 until dm_ack.
    - On ack: capture result, MEM_stall=0, return to IDLE.
- Store lanes:
  - byte: be = 0001<<addr[1:0], wdata = {4{RD2[7:0]}}.
  - half: be = 0011<<addr[1:0], wdata = {2{RD2[15:0]}}.
  - word: be = 1111.
- Load: select lane by addr[1:0], then sign- or zero-extend per dm_ctrl.
- WB_WD mux: aluout / extended load / PC+4 (32-bit wrap). WDSel 11 selects aluout.
- While MEM_stall=1, the WB register loads a bubble (RegWrite=0, rd=0).
- Interrupt handling:
  - INT_detected in IDLE: snapshot the current WB register into a backup and hold the register. WB_* outputs read 0 while INT_detected=1.
  - INT_detected in WAIT: the access is never abandoned. The request stays up until ack, and the completed result is written to the backup, not the WB register.
  - INT_restore: WB register <- backup.
  - INT_detected has priority over INT_restore.
- Reset (reset=0, async): state IDLE, all outputs 0, backup cleared. A reset mid-WAIT drops dm_req immediately.

## Timing
- Non-memory instruction: WB_* valid one edge after MEM_* presented.
- Memory access with ack after N wait cycles (N=0 for same-cycle ack):
  - MEM_stall high for N cycles.
  - WB_* updates on the edge where dm_ack=1.
- dm_req is never deasserted before dm_ack. At most one outstanding access.
- dm_rdata is sampled only in the cycle with dm_ack=1.
- MEM_misalign asserts combinationally in the cycle the access is presented.

## Structure
- Shared package pcpu_pkg holds:
  - dm_ctrl encodings (DM_WORD..DM_BYTE_U)
  - WDSel encodings (WD_ALU, WD_MEM, WD_PC4)
  - FSM state constants (S_IDLE, S_WAIT)
- One sub-module, dm_align: combinational store-lane/byte-enable generation and load lane select/extend. Keeping it separate lets the align logic be unit-tested.
- The FSM and the WB/backup registers live in mem_wb_stage.

## Test plan
- ALU op: aluout=0x1234, WDSel=00, rd=5, RegWrite=1. Expect after 1 edge: WB_WD=0x1234, WB_rd=5, MEM_stall never high.
- Byte load, signed, with 2-cycle ack latency: addr=0x102, dm_rdata=0x00800000, dm_ctrl=011. Expect:
  - dm_addr=0x100, MEM_stall high for 2 cycles.
  - WB_WD=0xFFFFFF80.
  - Repeating with dm_ctrl=100 gives 0x00000080.
- Half store, zero-wait: addr=0x06, RD2=0xABCD1234, same-cycle ack. Expect dm_be=1100, dm_wdata=0x12341234, dm_we=1, no stall.
- Misaligned word load at 0x101: expect dm_req=0, MEM_misalign=1, WB_RegWrite=0.
- Interrupt during a load:
  - INT_detected while in WAIT: WB_*=0, then ack with 0xDEADBEEF.
  - INT_restore: WB_WD=0xDEADBEEF.
- Reset mid-WAIT: dm_req, MEM_stall and all WB_* go to 0 asynchronously, and the FSM restarts in IDLE.

Source files
------------

// File: rtl/pcpu_pkg.sv
// Shared pipeline types for the pcpu core.
// Data-memory access encodings, write-back select codes and stage bundles.
package pcpu_pkg;

  localparam int DM_CTRL_W = 3;

  localparam logic [DM_CTRL_W-1:0] DM_WORD   = 3'b000;
  localparam logic [DM_CTRL_W-1:0] DM_HALF   = 3'b001;
  localparam logic [DM_CTRL_W-1:0] DM_HALF_U = 3'b010;
  localparam logic [DM_CTRL_W-1:0] DM_BYTE   = 3'b011;
  localparam logic [DM_CTRL_W-1:0] DM_BYTE_U = 3'b100;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0]          pc;
    logic [4:0]           rd;
    logic [31:0]          rd2;
    logic [DM_CTRL_W-1:0] ctrl;
    logic                 rw;
    logic                 mem_w;
    logic [31:0]          alu;
    logic [1:0]           wdsel;
  } mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] wd;
  } wb_t;

endpackage

// File: rtl/dm_align.sv
// Byte-lane alignment for data-memory stores and loads.
// Pure combinational: lanes, byte enables, load extend, misalign flag.
module dm_align
  import pcpu_pkg::*;
(
  input  logic [DM_CTRL_W-1:0] ctrl,
  input  logic [1:0]           addr_lo,
  input  logic [31:0]          st_data,
  input  logic [31:0]          rdata,
  output logic [3:0]           be,
  output logic [31:0]          wdata,
  output logic [31:0]          ld_data,
  output logic                 misalign
);

  logic        is_byte;
  logic        is_half;
  logic        is_sgn;
  logic [31:0] sh;

  assign is_byte = (ctrl == DM_BYTE) | (ctrl == DM_BYTE_U);
  assign is_half = (ctrl == DM_HALF) | (ctrl == DM_HALF_U);
  assign is_sgn  = (ctrl == DM_BYTE) | (ctrl == DM_HALF);
  assign sh      = rdata >> {addr_lo, 3'b000};

  always_comb begin
    be       = 4'b1111;
    wdata    = st_data;
    ld_data  = rdata;
    misalign = 1'b0;
    unique case (1'b1)
      is_byte: begin
        be      = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{is_sgn & sh[7]}}, sh[7:0]};
      end
      is_half: begin
        be       = 4'b0011 << addr_lo;
        wdata    = {2{st_data[15:0]}};
        ld_data  = {{16{is_sgn & sh[15]}}, sh[15:0]};
        misalign = addr_lo[0];
      end
      default: begin
        misalign = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB register with req/ack data port.
// Holds the access across wait states and snapshots WB on interrupts.
module mem_wb_stage
  import pcpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 INT_detected,
  input  logic                 INT_restore,
  input  logic [31:0]          MEM_PC,
  input  logic [4:0]           MEM_rd,
  input  logic [31:0]          MEM_RD2,
  input  logic [DM_CTRL_W-1:0] MEM_dm_ctrl,
  input  logic                 MEM_RegWrite,
  input  logic                 MEM_mem_w,
  input  logic [31:0]          MEM_aluout,
  input  logic [1:0]           MEM_WDSel,
  output logic                 dm_req,
  output logic                 dm_we,
  output logic [31:0]          dm_addr,
  output logic [3:0]           dm_be,
  output logic [31:0]          dm_wdata,
  input  logic [31:0]          dm_rdata,
  input  logic                 dm_ack,
  output logic                 MEM_stall,
  output logic                 MEM_misalign,
  output logic [31:0]          WB_PC,
  output logic [4:0]           WB_rd,
  output logic                 WB_RegWrite,
  output logic [31:0]          WB_WD
);

  state_t state_q, state_d;
  mem_t   hold_q, hold_d;
  wb_t    wb_q, wb_d;
  wb_t    bk_q, bk_d;
  logic   int_q;

  mem_t        in_b;
  mem_t        cur;
  wb_t         res;
  logic        in_wait;
  logic        is_mem;
  logic        start;
  logic        mis;
  logic        req;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_ld;
  logic        al_mis;

  always_comb begin
    in_b.pc    = MEM_PC;
    in_b.rd    = MEM_rd;
    in_b.rd2   = MEM_RD2;
    in_b.ctrl  = MEM_dm_ctrl;
    in_b.rw    = MEM_RegWrite;
    in_b.mem_w = MEM_mem_w;
    in_b.alu   = MEM_aluout;
    in_b.wdsel = MEM_WDSel;
  end

  // In WAIT the held copy drives the port so upstream may change freely.
  assign in_wait = (state_q == S_WAIT);
  assign cur     = in_wait ? hold_q : in_b;
  assign is_mem  = cur.mem_w | (cur.wdsel == WD_MEM);
  assign start   = ~in_wait & is_mem & ~INT_detected & ~INT_restore;
  assign mis     = start & al_mis;
  assign req     = reset & (in_wait | (start & ~al_mis));

  dm_align u_align (
    .ctrl     (cur.ctrl),
    .addr_lo  (cur.alu[1:0]),
    .st_data  (cur.rd2),
    .rdata    (dm_rdata),
    .be       (al_be),
    .wdata    (al_wdata),
    .ld_data  (al_ld),
    .misalign (al_mis)
  );

  assign dm_req       = req;
  assign dm_we        = req & cur.mem_w;
  assign dm_addr      = req ? {cur.alu[31:2], 2'b00} : 32'h0;
  assign dm_be        = req ? al_be : 4'b0000;
  assign dm_wdata     = req ? al_wdata : 32'h0;
  assign MEM_stall    = req & ~dm_ack;
  assign MEM_misalign = reset & mis;

  always_comb begin
    res.pc = cur.pc;
    res.rd = cur.rd;
    res.rw = cur.rw & ~mis;
    unique case (1'b1)
      (cur.wdsel == WD_MEM): res.wd = al_ld;
      (cur.wdsel == WD_PC4): res.wd = cur.pc + 32'd4;
      default:               res.wd = cur.alu;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (req & ~dm_ack) begin
          state_d = S_WAIT;
          hold_d  = in_b;
        end
      end
      S_WAIT: begin
        if (dm_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // An access finishing under an interrupt lands in the backup only.
  always_comb begin
    wb_d = wb_q;
    bk_d = bk_q;
    if (INT_detected) begin
      if (in_wait) begin
        if (dm_ack) bk_d = res;
      end else if (!int_q) begin
        bk_d = wb_q;
      end
    end else if (INT_restore) begin
      wb_d = bk_q;
    end else if (MEM_stall) begin
      wb_d = '0;
    end else begin
      wb_d = res;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      wb_q    <= '0;
      bk_q    <= '0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wb_q    <= wb_d;
      bk_q    <= bk_d;
      int_q   <= INT_detected;
    end
  end

  assign WB_PC       = INT_detected ? 32'h0 : wb_q.pc;
  assign WB_rd       = INT_detected ? 5'h0 : wb_q.rd;
  assign WB_RegWrite = ~INT_detected & wb_q.rw;
  assign WB_WD       = INT_detected ? 32'h0 : wb_q.wd;

endmodule
